// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial wide adder built around a 4-bit carry look-ahead cell.
// Operands are captured over a valid/ready handshake, summed four bits per
// clock (least-significant nibble first), and the WIDTH-bit result plus
// carry-out is presented over a second valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high; valid, once raised, holds its payload
// stable until that edge; ready may be high without valid and has no effect.

// 4-bit carry look-ahead adder: all internal carries come from generate and
// propagate terms rather than rippling through the bits.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Look-ahead carries and the per-bit sums.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// WIDTH must be a multiple of 4 and at least 4.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Current FSM state is kept as a named enum so checkers can observe it.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last_nib;

  // The low nibble of the shifted operands always feeds the single adder cell.
  cla4 u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  assign last_nib = (idx == IDXW'(NIB - 1));

  // Accumulator with the current nibble merged in; used both for the step
  // update and for the final result so the last nibble is not lost.
  always_comb begin
    acc_next = acc;
    acc_next[4*int'(idx) +: 4] = nib_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)  state_next = S_ADD;
      S_ADD:   if (last_nib)  state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Datapath: operand capture, per-nibble accumulation, result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            idx   <= '0;
            acc   <= '0;
          end
        end
        S_ADD: begin
          acc   <= acc_next;
          carry <= nib_cout;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          idx   <= idx + IDXW'(1);
          if (last_nib) begin
            sum  <= acc_next;
            cout <= nib_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
